// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: memory-wait FSM, redirect flush, load-use stall, watchdog.
// Optional performance counters are built only when HAZARD_PERF_EN is defined.
module hazard_ctrl #(
  parameter int REG_AW      = 5,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_rs1_en,
  input  logic              id_rs2_en,
  input  logic              ex_is_load,
  input  logic              ex_reg_wen,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              mem_req,
  input  logic              mem_ready,
  input  logic              ex_redirect,
  output logic              pc_stall,
  output logic              ifid_stall,
  output logic              ifid_flush,
  output logic              idex_stall,
  output logic              idex_flush,
  output logic              exmem_stall,
  output logic              memwb_bubble,
  output logic              mem_timeout,
  output logic [31:0]       stall_cycles,
  output logic [31:0]       flush_events
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MWAIT    = 2'd1,
    ST_MWAIT_RD = 2'd2
  } state_e;

  localparam int CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(MEM_TIMEOUT);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             mem_timeout_q, mem_timeout_d;

  logic mem_stall;
  logic load_use;
  logic redirect_flush;

  assign mem_stall = mem_req && !mem_ready;

  assign load_use = ex_is_load && ex_reg_wen && (ex_rd != '0) &&
                    ((id_rs1_en && (id_rs1 == ex_rd)) ||
                     (id_rs2_en && (id_rs2 == ex_rd)));

  // A pending redirect is released on the cycle the wait ends.
  assign redirect_flush = !mem_stall && (ex_redirect || (state_q == ST_MWAIT_RD));

  // NOTE: every output gets a default first so no path can infer a latch.
  always_comb begin
    pc_stall     = 1'b0;
    ifid_stall   = 1'b0;
    ifid_flush   = 1'b0;
    idex_stall   = 1'b0;
    idex_flush   = 1'b0;
    exmem_stall  = 1'b0;
    memwb_bubble = 1'b0;
    if (mem_stall) begin
      pc_stall     = 1'b1;
      ifid_stall   = 1'b1;
      idex_stall   = 1'b1;
      exmem_stall  = 1'b1;
      memwb_bubble = 1'b1;
    end else if (redirect_flush) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (load_use) begin
      pc_stall   = 1'b1;
      ifid_stall = 1'b1;
      idex_flush = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RUN: begin
        if (mem_stall) state_d = ex_redirect ? ST_MWAIT_RD : ST_MWAIT;
      end
      ST_MWAIT: begin
        if (!mem_stall)       state_d = ST_RUN;
        else if (ex_redirect) state_d = ST_MWAIT_RD;
      end
      ST_MWAIT_RD: begin
        if (!mem_stall) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_comb begin
    wait_cnt_d    = '0;
    mem_timeout_d = mem_timeout_q;
    if (state_d != ST_RUN) begin
      wait_cnt_d = (wait_cnt_q < TO_VAL) ? wait_cnt_q + 1'b1 : wait_cnt_q;
    end
    if ((MEM_TIMEOUT != 0) && (state_d != ST_RUN) && (wait_cnt_d == TO_VAL)) begin
      mem_timeout_d = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_RUN;
      wait_cnt_q    <= '0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  assign mem_timeout = mem_timeout_q;

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [31:0] flush_events_q, flush_events_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_events_d = flush_events_q;
    if (pc_stall && (stall_cycles_q != 32'hFFFF_FFFF)) begin
      stall_cycles_d = stall_cycles_q + 32'd1;
    end
    if (redirect_flush && (flush_events_q != 32'hFFFF_FFFF)) begin
      flush_events_d = flush_events_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles_q <= '0;
      flush_events_q <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_events_q <= flush_events_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_events = flush_events_q;
`else
  assign stall_cycles = '0;
  assign flush_events = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: vector table, directed multi-cycle sequences,
// and randomized stimulus against an event-level reference model.
module tb_hazard_ctrl;

  localparam int TB_TO = 4;

  typedef struct packed {
    logic       mem_req;
    logic       mem_ready;
    logic       ex_redirect;
    logic       ex_is_load;
    logic       ex_reg_wen;
    logic [4:0] ex_rd;
    logic       id_rs1_en;
    logic [4:0] id_rs1;
    logic       id_rs2_en;
    logic [4:0] id_rs2;
  } in_t;

  typedef struct {
    in_t        i;
    logic [6:0] o;
    string      name;
  } vec_t;

  // Output bit order: {pc, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem, memwb}
  localparam logic [6:0] O_NONE  = 7'b000_0000;
  localparam logic [6:0] O_MEM   = 7'b110_1011;
  localparam logic [6:0] O_FLUSH = 7'b001_0100;
  localparam logic [6:0] O_LU    = 7'b110_0100;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic id_rs1_en, id_rs2_en, ex_is_load, ex_reg_wen, mem_req, mem_ready, ex_redirect;
  logic pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_stall, memwb_bubble;
  logic mem_timeout;
  logic [31:0] stall_cycles, flush_events;
  logic [6:0] o_act;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state: pending redirect, wait length, sticky timeout, event counts.
  bit          m_pend;
  int          m_wait;
  bit          m_to;
  int unsigned m_stalls;
  int unsigned m_flushes;

  always #5 clk = ~clk;

  assign o_act = {pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush,
                  exmem_stall, memwb_bubble};

  hazard_ctrl #(.REG_AW(5), .MEM_TIMEOUT(TB_TO)) dut (
    .clk          (clk),
    .rst          (rst),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_rs1_en    (id_rs1_en),
    .id_rs2_en    (id_rs2_en),
    .ex_is_load   (ex_is_load),
    .ex_reg_wen   (ex_reg_wen),
    .ex_rd        (ex_rd),
    .mem_req      (mem_req),
    .mem_ready    (mem_ready),
    .ex_redirect  (ex_redirect),
    .pc_stall     (pc_stall),
    .ifid_stall   (ifid_stall),
    .ifid_flush   (ifid_flush),
    .idex_stall   (idex_stall),
    .idex_flush   (idex_flush),
    .exmem_stall  (exmem_stall),
    .memwb_bubble (memwb_bubble),
    .mem_timeout  (mem_timeout),
    .stall_cycles (stall_cycles),
    .flush_events (flush_events)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic in_t mk_in(input logic req, input logic rdy, input logic redir,
                                input logic ld, input logic wen, input logic [4:0] rd,
                                input logic r1en, input logic [4:0] r1,
                                input logic r2en, input logic [4:0] r2);
    in_t v;
    v.mem_req     = req;
    v.mem_ready   = rdy;
    v.ex_redirect = redir;
    v.ex_is_load  = ld;
    v.ex_reg_wen  = wen;
    v.ex_rd       = rd;
    v.id_rs1_en   = r1en;
    v.id_rs1      = r1;
    v.id_rs2_en   = r2en;
    v.id_rs2      = r2;
    return v;
  endfunction

  task automatic drive(input in_t v);
    mem_req     = v.mem_req;
    mem_ready   = v.mem_ready;
    ex_redirect = v.ex_redirect;
    ex_is_load  = v.ex_is_load;
    ex_reg_wen  = v.ex_reg_wen;
    ex_rd       = v.ex_rd;
    id_rs1_en   = v.id_rs1_en;
    id_rs1      = v.id_rs1;
    id_rs2_en   = v.id_rs2_en;
    id_rs2      = v.id_rs2;
  endtask

  function automatic bit is_load_use(input in_t v);
    if (!(v.ex_is_load && v.ex_reg_wen) || v.ex_rd == 5'd0) return 1'b0;
    return (v.id_rs1_en && v.id_rs1 == v.ex_rd) || (v.id_rs2_en && v.id_rs2 == v.ex_rd);
  endfunction

  function automatic logic [6:0] model_out(input in_t v);
    if (v.mem_req && !v.mem_ready)  return O_MEM;
    if (m_pend || v.ex_redirect)    return O_FLUSH;
    if (is_load_use(v))             return O_LU;
    return O_NONE;
  endfunction

  function automatic void model_reset();
    m_pend    = 1'b0;
    m_wait    = 0;
    m_to      = 1'b0;
    m_stalls  = 0;
    m_flushes = 0;
  endfunction

  function automatic void model_clock(input in_t v);
    logic [6:0] o;
    bit stalled;
    o = model_out(v);
    stalled = v.mem_req && !v.mem_ready;
    if (o[6]) m_stalls++;
    if (!stalled && (m_pend || v.ex_redirect)) m_flushes++;
    if (stalled) begin
      m_pend = m_pend || v.ex_redirect;
      m_wait++;
      if (TB_TO != 0 && m_wait >= TB_TO) m_to = 1'b1;
    end else begin
      m_pend = 1'b0;
      m_wait = 0;
    end
  endfunction

  task automatic step(input in_t v, input logic [6:0] exp_o, input string name);
    @(negedge clk);
    drive(v);
    #1;
    check(name, 32'(o_act), 32'(exp_o));
    check({name, "/timeout"}, 32'(mem_timeout), 32'(m_to));
`ifdef HAZARD_PERF_EN
    check({name, "/stall_cycles"}, stall_cycles, m_stalls);
    check({name, "/flush_events"}, flush_events, m_flushes);
`else
    check({name, "/stall_cycles"}, stall_cycles, 32'd0);
    check({name, "/flush_events"}, flush_events, 32'd0);
`endif
    model_clock(v);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    drive('0);
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  in_t  idle;
  in_t  lu5;
  in_t  stall_v;
  in_t  stall_rd;
  in_t  ready_v;
  vec_t tbl[11];

  initial begin
    idle     = '0;
    lu5      = mk_in(0, 0, 0, 1, 1, 5'd5, 0, 5'd0, 1, 5'd5);
    stall_v  = mk_in(1, 0, 0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0);
    stall_rd = mk_in(1, 0, 1, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0);
    ready_v  = mk_in(1, 1, 0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0);

    tbl[0]  = '{idle, O_NONE, "idle"};
    tbl[1]  = '{lu5, O_LU, "lu_rs2"};
    tbl[2]  = '{mk_in(0, 0, 0, 0, 0, 5'd5, 0, 5'd0, 1, 5'd5), O_NONE, "lu_bubble"};
    tbl[3]  = '{mk_in(0, 0, 0, 1, 1, 5'd0, 0, 5'd0, 1, 5'd0), O_NONE, "lu_rd0"};
    tbl[4]  = '{mk_in(0, 0, 1, 1, 1, 5'd5, 0, 5'd0, 1, 5'd5), O_FLUSH, "lu_redirect"};
    tbl[5]  = '{mk_in(0, 0, 0, 1, 1, 5'd7, 1, 5'd7, 0, 5'd0), O_LU, "lu_rs1"};
    tbl[6]  = '{mk_in(0, 0, 0, 1, 1, 5'd7, 0, 5'd7, 0, 5'd7), O_NONE, "lu_disabled"};
    tbl[7]  = '{mk_in(0, 0, 0, 1, 0, 5'd7, 1, 5'd7, 1, 5'd7), O_NONE, "lu_no_wen"};
    tbl[8]  = '{mk_in(0, 0, 1, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0), O_FLUSH, "redirect"};
    tbl[9]  = '{mk_in(0, 0, 0, 1, 1, 5'd9, 1, 5'd3, 1, 5'd4), O_NONE, "lu_miss"};
    tbl[10] = '{mk_in(0, 1, 0, 1, 1, 5'd31, 1, 5'd31, 0, 5'd0), O_LU, "lu_r31"};

    drive(idle);
    model_reset();
    rst = 1'b1;
    #12;
    check("reset/timeout", 32'(mem_timeout), 32'd0);
    check("reset/stall_cycles", stall_cycles, 32'd0);
    check("reset/flush_events", flush_events, 32'd0);
    drive(lu5);
    #1;
    check("reset/lu_follows_inputs", 32'(o_act), 32'(O_LU));
    drive(idle);
    @(negedge clk);
    rst = 1'b0;

    foreach (tbl[k]) step(tbl[k].i, tbl[k].o, tbl[k].name);

    // Redirect latched during a memory wait, released once when the wait ends.
    do_reset();
    step(stall_v,  O_MEM,   "mw_c1");
    step(stall_rd, O_MEM,   "mw_c2_redirect");
    step(stall_v,  O_MEM,   "mw_c3");
    step(ready_v,  O_FLUSH, "mw_release");
    step(idle,     O_NONE,  "mw_after");
`ifdef HAZARD_PERF_EN
    check("mw/stall_cycles_3", stall_cycles, 32'd3);
    check("mw/flush_events_1", flush_events, 32'd1);
`endif

    // Pending redirect held across a wait that resumes immediately.
    step(stall_rd, O_MEM,   "hold_c1");
    step(stall_v,  O_MEM,   "hold_c2");
    step(stall_v,  O_MEM,   "hold_c3");
    step(idle,     O_FLUSH, "hold_release");
    step(lu5,      O_LU,    "hold_then_lu");

    // Watchdog: sets after four wait cycles and stays set.
    do_reset();
    for (int c = 1; c <= 6; c++) begin
      step(stall_v, O_MEM, $sformatf("wd_c%0d", c));
      if (c == 3) check("wd/not_yet", 32'(mem_timeout), 32'd0);
    end
    check("wd/set", 32'(mem_timeout), 32'd1);
    step(ready_v, O_NONE, "wd_ready");
    step(idle,    O_NONE, "wd_idle");
    check("wd/sticky", 32'(mem_timeout), 32'd1);

    // Asynchronous reset in the middle of a redirect-pending wait.
    do_reset();
    step(stall_rd, O_MEM, "rr_c1");
    for (int c = 2; c <= 5; c++) step(stall_v, O_MEM, $sformatf("rr_c%0d", c));
    @(negedge clk);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check("rr/timeout_cleared", 32'(mem_timeout), 32'd0);
    check("rr/stall_cycles", stall_cycles, 32'd0);
    check("rr/flush_events", flush_events, 32'd0);
    drive(lu5);
    #1;
    check("rr/run_rules_in_reset", 32'(o_act), 32'(O_LU));
    @(negedge clk);
    rst = 1'b0;
    step(idle, O_NONE, "rr_no_flush");

    // Randomized traffic against the reference model.
    do_reset();
    for (int n = 0; n < 600; n++) begin
      in_t v;
      v.mem_req     = ($urandom_range(0, 99) < 45);
      v.mem_ready   = ($urandom_range(0, 99) < 40);
      v.ex_redirect = ($urandom_range(0, 99) < 20);
      v.ex_is_load  = 1'($urandom_range(0, 1));
      v.ex_reg_wen  = ($urandom_range(0, 99) < 80);
      v.ex_rd       = 5'($urandom_range(0, 3));
      v.id_rs1_en   = 1'($urandom_range(0, 1));
      v.id_rs1      = 5'($urandom_range(0, 3));
      v.id_rs2_en   = 1'($urandom_range(0, 1));
      v.id_rs2      = 5'($urandom_range(0, 3));
      step(v, model_out(v), "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "bench time limit expired");
  end

endmodule
